// File: rtl/multicycle_control.sv
// Control unit for the 8-bit multicycle MIPS datapath: Moore FSM sequencing
// fetch/decode/execute/memory/writeback plus the ALU control decoder.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_DECODE, S_MEMADR,
    S_LBRD, S_LBWR, S_SBWR, S_RTYPEEX, S_RTYPEWR, S_BEQEX, S_JEX,
    S_ADDIEX, S_ADDIWR
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t state_q, state_d;
  state_t cur;
  aluop_t aluop;
  logic   pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH1;
    unique case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_FETCH4;
      S_FETCH4: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SB) ? S_SBWR : S_LBRD;
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_ADDIEX:  state_d = S_ADDIWR;
      default:   state_d = S_FETCH1;
    endcase
  end

  // While reset is held the outputs decode as FETCH1, with every write and
  // read strobe masked so nothing in the datapath or memory changes.
  always_comb begin
    cur      = reset ? S_FETCH1 : state_q;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    irwrite  = 4'b0000;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    pcsource = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    unique case (cur)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread = 1'b1;
        iord    = 1'b1;
        alusrca = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        case (cur)
          S_FETCH1: irwrite = 4'b0001;
          S_FETCH2: irwrite = 4'b0010;
          S_FETCH3: irwrite = 4'b0100;
          default:  irwrite = 4'b1000;
        endcase
      end
      S_DECODE: begin
        alusrca = 1'b1;
        alusrcb = 2'b11;
      end
      S_MEMADR, S_ADDIEX: alusrcb = 2'b10;
      S_LBRD:             memread = 1'b1;
      S_LBWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_SBWR:             memwrite = 1'b1;
      S_RTYPEEX:          aluop = ALUOP_FUNCT;
      S_RTYPEWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_BEQEX: begin
        aluop    = ALUOP_SUB;
        branch   = 1'b1;
        pcsource = 2'b01;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_ADDIWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        regdst   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      memread  = 1'b0;
      irwrite  = 4'b0000;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
    pcen = pcwrite | (branch & zero);
  end

  always_comb begin
    alucontrol = 3'b010;
    unique case (aluop)
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle outputs are compared
// against a per-instruction step table derived from the instruction semantics.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int last_len = 0;
  int prev_len = 0;

  localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  // FETCH1 outputs with the read strobe, IR load and PC enable masked
  localparam logic [18:0] RST_VEC = {1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 4'b0000,
                                     1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010};

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .pcsource(pcsource), .pcen(pcen),
    .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // Measures the DUT's own instruction length: cycles between FETCH1 showings.
  always @(negedge clk) begin
    if (reset) cnt = 0;
    else if (irwrite == 4'b0001) begin
      last_len = cnt;
      cnt = 1;
    end else cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] fdec(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int ilen(input logic [5:0] opc);
    case (opc)
      LB:                 return 8;
      SB, RT, ADDI:       return 7;
      BEQ, JMP:           return 6;
      default:            return 5;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = FETCH1) of instruction opc.
  function automatic logic [18:0] model(input logic [5:0] opc, input int k,
                                        input logic [5:0] f, input logic z);
    logic mr = 0, mw = 0, asa = 0, io = 0, mtr = 0, rd = 0, rw = 0, pe = 0;
    logic [1:0] asb = 0, ps = 0;
    logic [3:0] irw = 0;
    logic [2:0] ac = 3'b010;
    if (k < 4) begin
      mr = 1; io = 1; asa = 1; asb = 2'b01; pe = 1; irw[k] = 1'b1;
    end else if (k == 4) begin
      asa = 1; asb = 2'b11;
    end else begin
      case (opc)
        LB: begin
          if (k == 5) asb = 2'b10;
          else if (k == 6) mr = 1;
          else begin rw = 1; rd = 1; end
        end
        SB:   if (k == 5) asb = 2'b10; else mw = 1;
        RT:   if (k == 5) ac = fdec(f); else begin rw = 1; mtr = 1; end
        BEQ:  begin ac = 3'b110; ps = 2'b01; pe = z; end
        JMP:  begin ps = 2'b10; pe = 1; end
        ADDI: if (k == 5) asb = 2'b10; else begin rw = 1; mtr = 1; rd = 1; end
        default: ;
      endcase
    end
    return {mr, mw, asa, asb, io, irw, mtr, rd, rw, ps, pe, ac};
  endfunction

  function automatic logic [18:0] outvec();
    return {memread, memwrite, alusrca, alusrcb, iord, irwrite,
            memtoreg, regdst, regwrite, pcsource, pcen, alucontrol};
  endfunction

  task automatic do_cycle(input string name, input logic [5:0] opc, input int k,
                          input logic use_f, input logic [5:0] f, input int zmode,
                          input logic rst);
    @(posedge clk); #1;
    reset = rst;
    op    = (k >= 4) ? opc : 6'($urandom);
    funct = use_f ? f : 6'($urandom);
    zero  = (zmode == 0) ? 1'($urandom) : (zmode == 1);
    @(negedge clk); #1;
    if (rst) check($sformatf("%s reset", name), 32'(outvec()), 32'(RST_VEC));
    else begin
      if (k == 0 && prev_len > 0)
        check($sformatf("%s prior latency", name), 32'(last_len), 32'(prev_len));
      check($sformatf("%s k%0d", name, k), 32'(outvec()), 32'(model(opc, k, funct, zero)));
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] opc,
                           input logic use_f, input logic [5:0] f, input int zmode);
    for (int k = 0; k < ilen(opc); k++) do_cycle(name, opc, k, use_f, f, zmode, 1'b0);
    prev_len = ilen(opc);
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fs  [6];
    ops = '{LB, SB, RT, BEQ, JMP, ADDI, 6'b111111};
    fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    for (int i = 0; i < 2; i++) do_cycle("init", 6'd0, 0, 1'b0, 6'd0, 0, 1'b1);

    foreach (fs[i]) run_instr($sformatf("rtype%0d", i), RT, 1'b1, fs[i], 0);
    run_instr("lb", LB, 1'b0, 6'd0, 0);
    run_instr("sb", SB, 1'b0, 6'd0, 0);
    run_instr("beq_taken", BEQ, 1'b0, 6'd0, 1);
    run_instr("beq_not", BEQ, 1'b0, 6'd0, 2);
    run_instr("j", JMP, 1'b0, 6'd0, 0);
    run_instr("addi", ADDI, 1'b0, 6'd0, 0);
    run_instr("illegal", 6'b111111, 1'b0, 6'd0, 1);

    // reset asserted for two cycles starting in LBRD
    for (int k = 0; k < 6; k++) do_cycle("lb_rst", LB, k, 1'b0, 6'd0, 0, 1'b0);
    do_cycle("lb_rst", LB, 6, 1'b0, 6'd0, 0, 1'b1);
    do_cycle("lb_rst", LB, 6, 1'b0, 6'd0, 0, 1'b1);
    prev_len = 0;
    run_instr("after_rst", LB, 1'b0, 6'd0, 0);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1)
        run_instr("rand", o, 1'b1, fs[$urandom_range(0, 5)], 0);
      else
        run_instr("rand", o, 1'b0, 6'd0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
